alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequential front end that drives the team's combinational ALU (Module_ALU) from a single user data bus. It captures operand A, operand B and the 4-bit opcode in three successive load strobes, presents them to the ALU, registers the result and flags, and holds a carry flag that is fed back as the ALU carry-in for multi-word add/subtract chains. It sits between the board input logic (switches plus debounced button) and the ALU/display path.

## Interface
- N, 4, operand/result width; must be >= 4 because the opcode is taken from data_i[3:0]
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- data_i  in  N  operand or opcode value entered by the user
- load_i  in  1  single-cycle strobe (already debounced/edge-detected) that captures data_i into the current field
- clear_i  in  1  single-cycle strobe that clears the carry flag and restarts entry
- alu_a_o  out  N  operand A to ALU (ALUA_i)
- alu_b_o  out  N  operand B to ALU (ALUB_i)
- alu_flag_in_o  out  1  stored carry flag to ALU (ALUFlagIn_i)
- alu_control_o  out  4  opcode to ALU (ALUControl_i)
- alu_result_i  in  N  ALU result (ALUResult_o)
- alu_carry_i  in  1  ALU carry (ALUCarry_o)
- alu_cero_i  in  1  ALU zero flag (ALUCero_o)
- result_o  out  N  registered result of the last legal operation
- carry_o  out  1  stored carry flag
- cero_o  out  1  registered zero flag of the last legal operation
- done_o  out  1  one-cycle pulse when an operation completes (legal or illegal)
- error_o  out  1  high while the last captured opcode is illegal; cleared when the next opcode is captured, by clear_i, or by reset
- state_o  out  3  current FSM state encoding, for debug LEDs

## Operation
- States: LOAD_A(0) -> LOAD_B(1) -> LOAD_OP(2) -> EXEC(3) -> DONE(4) -> LOAD_A.
- In LOAD_A/LOAD_B/LOAD_OP, load_i captures data_i into the A, B or op register (op = data_i[3:0]) and advances the state. No load_i means the FSM holds its state.
- Legal opcodes: 0000 OR, 0001 AND, 0010 SUB, 0011 ADD, 1100 shift-left logical. Any other value is illegal.
- In EXEC with a legal opcode: result_o <= alu_result_i, cero_o <= alu_cero_i, carry flag <= alu_carry_i, error_o <= 0.
- In EXEC with an illegal opcode: result_o, cero_o and the carry flag hold their values, and error_o <= 1.
- The alu_*_o outputs are driven directly from the A, B and op registers and the carry flag. They stay stable from capture through EXEC.
- DONE: done_o = 1 for exactly one cycle, then the FSM returns to LOAD_A.
- load_i is ignored in EXEC and DONE.
- clear_i in any state: carry flag <= 0, error_o <= 0, state <= LOAD_A. The A, B, op and result registers are kept.
- If clear_i and load_i arrive in the same cycle, clear_i wins.
- All arithmetic wrapping is done by the ALU. This block only registers values and does no width extension.

## Timing
- Reset: state LOAD_A, and the A, B and op registers = 0. Every output is 0: result_o, carry_o, cero_o, done_o, error_o, state_o, alu_a_o, alu_b_o, alu_flag_in_o and alu_control_o.
- If rst_i is asserted mid-operation (including during EXEC), the result is not registered and done_o is not pulsed.
- Latency: a load_i that captures the opcode in cycle k puts the FSM in EXEC in cycle k+1. result_o, carry_o, cero_o and error_o are updated and done_o = 1 in cycle k+2.
- Minimum operation time: 5 cycles from the first load_i to done_o, assuming back-to-back strobes.

## Configuration
- ALU_SEQ_CHAIN_EN defined: accumulator mode. After the first completed operation, DONE returns to LOAD_B and alu_a_o is driven from result_o, so only B and the opcode are entered. Before any operation completes, and after clear_i or reset, entry starts at LOAD_A.
- ALU_SEQ_CHAIN_EN undefined: every operation starts at LOAD_A as described above.

## Structure
- Shared package alu_pkg contains:
  - typedef enum logic [3:0] alu_op_e {OP_OR, OP_AND, OP_SUB, OP_ADD, OP_SLL} with the encodings above
  - typedef enum logic [2:0] seq_state_e for the FSM states
  - function is_legal_op(logic [3:0])
- Single module with no sub-module. The ALU is instantiated beside this block at the parent level, not inside it.

## Test plan
1. Reset, then enter A=3, B=5, op=0011 -> two cycles after the opcode strobe: result_o=8, carry_o=0, cero_o=0, done_o pulses once.
2. Enter A=F, B=1, ADD -> result_o=0, carry_o=1, cero_o=1. Then enter A=0, B=0, ADD -> alu_flag_in_o=1 and result_o=1, carry_o=0.
3. After a completed op with result_o=8, enter op=0101 -> error_o=1, done_o pulses, result_o stays 8, carry_o unchanged.
4. In LOAD_B with carry_o=1, pulse clear_i together with load_i -> state_o=0, carry_o=0, B register not loaded.
5. Assert rst_i during EXEC -> the next cycle has all outputs 0, state_o=0, and done_o is never pulsed.
6. With ALU_SEQ_CHAIN_EN: enter A=2, B=3, ADD -> result_o=5. Then enter only B=1, op=0010 -> result_o=4, carry_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front end (alu_op_sequencer) and the
// combinational ALU it drives.
//   alu_op_e     - 4-bit ALU opcodes understood by the ALU
//   seq_state_e  - operand/opcode entry FSM states (encoding shown on LEDs)
//   is_legal_op  - true for the opcodes the ALU implements
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_OR  = 4'b0000,
        OP_AND = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SLL = 4'b1100
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_OR, OP_AND, OP_SUB, OP_ADD, OP_SLL: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Sequential front end for the combinational ALU. Operand A, operand B and a
// 4-bit opcode are captured from one user data bus by three successive load
// strobes, presented to the ALU, and the ALU result/flags are registered. The
// stored carry flag is fed back as the ALU carry-in so add/subtract operations
// can be chained across words.
//
// Optional feature (compile-time macro ALU_SEQ_CHAIN_EN):
//   defined   - accumulator mode: after the first completed operation the
//               previous result is used as operand A and entry restarts at
//               LOAD_B. Reset and clear_i return to full A/B/op entry.
//   undefined - every operation starts at LOAD_A.
//
// Ports
//   clk_i          in   1  clock
//   rst_i          in   1  synchronous active-high reset
//   data_i         in   N  operand / opcode value from the user
//   load_i         in   1  single-cycle strobe capturing data_i into current field
//   clear_i        in   1  single-cycle strobe: clear carry/error, restart entry
//   alu_a_o        out  N  operand A to ALU
//   alu_b_o        out  N  operand B to ALU
//   alu_flag_in_o  out  1  stored carry to ALU carry-in
//   alu_control_o  out  4  opcode to ALU
//   alu_result_i   in   N  ALU result
//   alu_carry_i    in   1  ALU carry out
//   alu_cero_i     in   1  ALU zero flag
//   result_o       out  N  registered result of the last legal operation
//   carry_o        out  1  stored carry flag
//   cero_o         out  1  registered zero flag of the last legal operation
//   done_o         out  1  one-cycle pulse when an operation completes
//   error_o        out  1  last captured opcode was illegal
//   state_o        out  3  FSM state encoding for debug LEDs
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] data_i,
    input  logic         load_i,
    input  logic         clear_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic         alu_flag_in_o,
    output logic [3:0]   alu_control_o,
    input  logic [N-1:0] alu_result_i,
    input  logic         alu_carry_i,
    input  logic         alu_cero_i,
    output logic [N-1:0] result_o,
    output logic         carry_o,
    output logic         cero_o,
    output logic         done_o,
    output logic         error_o,
    output logic [2:0]   state_o
);

    // The opcode is taken from the low nibble of the data bus.
    if (N < 4) begin : g_width_check
        $error("alu_op_sequencer: N must be >= 4");
    end

    seq_state_e   state_q,  state_d;
    logic [N-1:0] a_q,      a_d;
    logic [N-1:0] b_q,      b_d;
    logic [3:0]   op_q,     op_d;
    logic [N-1:0] result_q, result_d;
    logic         carry_q,  carry_d;
    logic         cero_q,   cero_d;
    logic         error_q,  error_d;
`ifdef ALU_SEQ_CHAIN_EN
    // Set once an operation has completed; selects the accumulator as operand A.
    logic         chain_q,  chain_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        cero_d   = cero_q;
        error_d  = error_q;
`ifdef ALU_SEQ_CHAIN_EN
        chain_d  = chain_q;
`endif

        case (state_q)
            ST_LOAD_A: begin
                if (load_i) begin
                    a_d     = data_i;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (load_i) begin
                    b_d     = data_i;
                    state_d = ST_LOAD_OP;
                end
            end
            ST_LOAD_OP: begin
                if (load_i) begin
                    op_d    = data_i[3:0];
                    // A fresh opcode supersedes any earlier illegal one.
                    error_d = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal opcodes leave result, zero and carry untouched.
                if (is_legal_op(op_q)) begin
                    result_d = alu_result_i;
                    cero_d   = alu_cero_i;
                    carry_d  = alu_carry_i;
                    error_d  = 1'b0;
                end else begin
                    error_d  = 1'b1;
                end
`ifdef ALU_SEQ_CHAIN_EN
                chain_d = 1'b1;
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef ALU_SEQ_CHAIN_EN
                state_d = chain_q ? ST_LOAD_B : ST_LOAD_A;
`else
                state_d = ST_LOAD_A;
`endif
            end
            default: begin
                state_d = ST_LOAD_A;
            end
        endcase

        // clear_i overrides everything above, including a simultaneous load_i
        // and an in-flight EXEC; the data registers keep their values.
        if (clear_i) begin
            state_d  = ST_LOAD_A;
            a_d      = a_q;
            b_d      = b_q;
            op_d     = op_q;
            result_d = result_q;
            cero_d   = cero_q;
            carry_d  = 1'b0;
            error_d  = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cero_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cero_q   <= cero_d;
            error_q  <= error_d;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q  <= chain_d;
`endif
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    assign alu_a_o = chain_q ? result_q : a_q;
`else
    assign alu_a_o = a_q;
`endif
    assign alu_b_o       = b_q;
    assign alu_control_o = op_q;
    assign alu_flag_in_o = carry_q;

    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign cero_o   = cero_q;
    assign error_o  = error_q;
    // DONE lasts exactly one cycle, so the pulse is the state itself.
    assign done_o   = (state_q == ST_DONE);
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] data_i;
    logic         load_i;
    logic         clear_i;
    logic [N-1:0] alu_a_o, alu_b_o;
    logic         alu_flag_in_o;
    logic [3:0]   alu_control_o;
    logic [N-1:0] alu_result_i;
    logic         alu_carry_i, alu_cero_i;
    logic [N-1:0] result_o;
    logic         carry_o, cero_o, done_o, error_o;
    logic [2:0]   state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.N(N)) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .load_i(load_i), .clear_i(clear_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_flag_in_o(alu_flag_in_o),
        .alu_control_o(alu_control_o), .alu_result_i(alu_result_i),
        .alu_carry_i(alu_carry_i), .alu_cero_i(alu_cero_i),
        .result_o(result_o), .carry_o(carry_o), .cero_o(cero_o),
        .done_o(done_o), .error_o(error_o), .state_o(state_o)
    );

    // Behavioural ALU: {carry, result}. Illegal opcodes produce a distinctive
    // value so that wrongly registering it is visible.
    function automatic logic [N:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [N:0] t;
        case (op)
            4'd0:    t = {1'b0, a | b};
            4'd1:    t = {1'b0, a & b};
            4'd2:    t = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
            4'd3:    t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            4'd12:   t = {1'b0, a << b};
            default: t = {1'b1, ~a};
        endcase
        return t;
    endfunction

    logic [N:0] alu_out;
    always_comb alu_out = alu_fn(alu_a_o, alu_b_o, alu_control_o, alu_flag_in_o);
    assign alu_result_i = alu_out[N-1:0];
    assign alu_carry_i  = alu_out[N];
    assign alu_cero_i   = (alu_out[N-1:0] == '0);

    // Reference model state
    typedef struct {
        logic [N-1:0] result;
        logic         carry;
        logic         cero;
        logic         err;
    } exp_t;
    exp_t exp_q[$];

    logic [N-1:0] ref_a, ref_b, ref_result;
    logic         ref_carry, ref_cero, ref_err;
    bit           ref_chain;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd12};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        load_i = 1'b0;
        repeat (n) begin
            data_i = N'($urandom);
            tick();
        end
    endtask

    task automatic load_val(input logic [N-1:0] d);
        data_i = d;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic model_reset();
        ref_a = '0; ref_b = '0; ref_result = '0;
        ref_carry = 1'b0; ref_cero = 1'b0; ref_err = 1'b0; ref_chain = 0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        load_i  = 1'b0;
        tick();
        clear_i   = 1'b0;
        ref_carry = 1'b0;
        ref_err   = 1'b0;
        ref_chain = 0;
    endtask

    // One full operation; in accumulator mode operand A is skipped once chaining.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] op, input bit rnd);
        exp_t         e;
        logic [N-1:0] a_eff;
        logic [N:0]   r;
        if (!ref_chain) begin
            idle(rnd ? $urandom_range(2) : 0);
            load_val(a);
            ref_a = a;
        end
        a_eff = ref_chain ? ref_result : ref_a;
        idle(rnd ? $urandom_range(2) : 0);
        load_val(b);
        ref_b = b;
        idle(rnd ? $urandom_range(2) : 0);
        if (legal(op)) begin
            r          = alu_fn(a_eff, b, op, ref_carry);
            ref_result = r[N-1:0];
            ref_carry  = r[N];
            ref_cero   = (r[N-1:0] == '0);
            ref_err    = 1'b0;
        end else begin
            ref_err = 1'b1;
        end
`ifdef ALU_SEQ_CHAIN_EN
        ref_chain = 1;
`endif
        e.result = ref_result; e.carry = ref_carry; e.cero = ref_cero; e.err = ref_err;
        exp_q.push_back(e);
        load_val(N'(op));
        chk("error_clear_on_op_capture", error_o, 0);
        chk("state_exec", state_o, 3);
        // Loads during EXEC and DONE must be ignored.
        repeat (2) begin
            load_i = rnd ? 1'($urandom) : 1'b0;
            data_i = N'($urandom);
            tick();
        end
        load_i = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    exp_t mon_e;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            chk("done_single_pulse", prev_done, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", done_o, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_o", result_o, mon_e.result);
                chk("carry_o", carry_o, mon_e.carry);
                chk("cero_o", cero_o, mon_e.cero);
                chk("error_o", error_o, mon_e.err);
                chk("alu_flag_in_o", alu_flag_in_o, mon_e.carry);
            end
        end
        prev_done = done_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [3:0] legal_ops [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12};

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_result"}, result_o, 0);
        chk({tag, "_flags"}, {carry_o, cero_o, done_o, error_o}, 0);
        chk({tag, "_alu_ab"}, {alu_a_o, alu_b_o}, 0);
        chk({tag, "_alu_ctl"}, {alu_flag_in_o, alu_control_o}, 0);
    endtask

    initial begin
        logic [3:0] op;
        rst_i = 1'b1; load_i = 1'b0; clear_i = 1'b0; data_i = '0;
        model_reset();
        repeat (3) tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        idle(2);
        chk("hold_without_load", state_o, 0);

        // 3 + 5
        do_op(4'h3, 4'h5, 4'b0011, 0);
        chk("t1_result", result_o, 8);
        chk("t1_carry", carry_o, 0);
        chk("t1_state_after", state_o, ref_chain ? 1 : 0);

        // Illegal opcode keeps result and carry
        do_op(4'h1, 4'h2, 4'b0101, 0);
        chk("t3_error", error_o, 1);
        chk("t3_result_held", result_o, 8);
        chk("t3_carry_held", carry_o, 0);

        // Carry out, then carry in
        pulse_clear();
        chk("clear_error", error_o, 0);
        do_op(4'hF, 4'h1, 4'b0011, 0);
        chk("t2a_result", {carry_o, cero_o, result_o}, {1'b1, 1'b1, 4'h0});
        chk("t2_flag_in", alu_flag_in_o, 1);
        do_op(4'h0, 4'h0, 4'b0011, 0);
        chk("t2b_result", {carry_o, result_o}, {1'b0, 4'h1});

        // clear_i beats load_i in LOAD_B
        do_op(4'hF, 4'h1, 4'b0011, 0);
        if (!ref_chain) begin
            load_val(4'h7);
            ref_a = 4'h7;
        end
        chk("t4_in_load_b", state_o, 1);
        chk("t4_carry_set", carry_o, 1);
        data_i = 4'h9; load_i = 1'b1; clear_i = 1'b1;
        tick();
        load_i = 1'b0; clear_i = 1'b0;
        ref_carry = 1'b0; ref_err = 1'b0; ref_chain = 0;
        chk("t4_state", state_o, 0);
        chk("t4_carry", carry_o, 0);
        chk("t4_b_not_loaded", alu_b_o, ref_b);

        // Reset during EXEC: no result registered, no done pulse
        load_val(4'h6); load_val(4'h7); load_val(4'h3);
        chk("t5_in_exec", state_o, 3);
        rst_i = 1'b1;
        tick();
        chk_all_zero("t5");
        rst_i = 1'b0;
        model_reset();
        idle(4);

`ifdef ALU_SEQ_CHAIN_EN
        pulse_clear();
        do_op(4'h2, 4'h3, 4'b0011, 0);
        chk("t6_result_a", result_o, 5);
        chk("t6_chain_state", state_o, 1);
        chk("t6_alu_a_acc", alu_a_o, 5);
        do_op(4'h0, 4'h1, 4'b0010, 0);
        chk("t6_result_b", {carry_o, result_o}, {1'b0, 4'h4});
`endif

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7) == 0) pulse_clear();
            if ($urandom_range(1) == 1) op = legal_ops[$urandom_range(4)];
            else                        op = 4'($urandom);
            do_op(N'($urandom), N'($urandom), op, 1);
        end

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
